data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_ram.sv | 27 ++
 rtl/data_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared state encoding and default widths for the data memory controller.
package dmem_pkg;

  localparam int DMEM_DATA_W = 12;
  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DEPTH  = 256;
  localparam int DMEM_BUS_W  = 17;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DONE     = 2'd1,
    ST_HOST_ACC = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, write-first, no reset on the array so it maps
// onto block RAM.
module dmem_ram #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write-first port: a write also forwards the new word to the read register.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: processor access while the program runs, then
// single-word host access until the host restarts the program.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int BUS_W  = DMEM_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_en,
  input  logic [ADDR_W-1:0] ar_in,
  input  logic [BUS_W-1:0]  bus_in,
  input  logic              end_process,
  output logic [DATA_W-1:0] dm_out,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_go,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              host_busy,
  output logic [15:0]       wr_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  dmem_state_e state, state_nxt;

  logic              proc_in_range, host_in_range, proc_wr;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic              lat_we, lat_in_range;
  logic [IDX_W-1:0]  lat_idx;
  logic [DATA_W-1:0] lat_wdata;

  logic              dm_valid;
  logic [DATA_W-1:0] dm_hold;
  logic              unused_bus;

  assign unused_bus    = ^bus_in[BUS_W-1:DATA_W];
  assign proc_in_range = ({1'b0, ar_in} < DEPTH_L);
  assign host_in_range = ({1'b0, host_addr} < DEPTH_L);
  assign proc_wr       = (state == ST_RUN) && dm_en && proc_in_range;
  assign host_busy     = (state != ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Next state; host_req wins over host_go in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (end_process) state_nxt = ST_DONE;
      ST_DONE:     if (host_req) state_nxt = ST_HOST_ACC;
                   else if (host_go) state_nxt = ST_RUN;
      ST_HOST_ACC: state_nxt = ST_DONE;
      default:     state_nxt = ST_RUN;
    endcase
  end

  // RAM port mux. In DONE the host address is read speculatively so the read
  // word is already on ram_rdata during HOST_ACC.
  always_comb begin
    ram_addr  = ar_in[IDX_W-1:0];
    ram_wdata = bus_in[DATA_W-1:0];
    ram_we    = 1'b0;
    case (state)
      ST_RUN:      ram_we = proc_wr;
      ST_DONE:     ram_addr = host_addr[IDX_W-1:0];
      ST_HOST_ACC: begin
        ram_addr  = lat_idx;
        ram_wdata = lat_wdata;
        ram_we    = lat_we && lat_in_range;
      end
      default:     ram_we = 1'b0;
    endcase
    if (rst) ram_we = 1'b0;
  end

  dmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .addr   (ram_addr),
    .wdata  (ram_wdata),
    .rdata  (ram_rdata)
  );

  // Capture the host request when it is accepted.
  always_ff @(posedge clk) begin
    if (state == ST_DONE && host_req) begin
      lat_we       <= host_we;
      lat_in_range <= host_in_range;
      lat_idx      <= host_addr[IDX_W-1:0];
      lat_wdata    <= host_wdata;
    end
  end

  // Host acknowledge and read data, registered out of HOST_ACC.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= (state == ST_HOST_ACC);
      if (state == ST_HOST_ACC && !lat_we)
        host_rdata <= lat_in_range ? ram_rdata : '0;
    end
  end

  // Processor read path: RAM output while the last access was an in-range
  // RUN read, otherwise a held value (zero after an out-of-range address).
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_valid <= 1'b0;
      dm_hold  <= '0;
    end else begin
      dm_valid <= (state == ST_RUN) && proc_in_range;
      dm_hold  <= (state == ST_RUN && !proc_in_range) ? '0 : dm_out;
    end
  end

  assign dm_out = dm_valid ? ram_rdata : dm_hold;

  // Saturating count of accepted processor writes, cleared on restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
    end else if (state == ST_RUN) begin
      if (proc_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end else if (state == ST_DONE && !host_req && host_go) begin
      wr_count <= '0;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, then randomized traffic
// against a behavioural model, then wr_count saturation.
module tb_data_mem_ctrl;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 256;
  localparam int BUS_W  = 17;

  logic              clk = 1'b0;
  logic              rst, dm_en, end_process;
  logic [ADDR_W-1:0] ar_in, host_addr;
  logic [BUS_W-1:0]  bus_in;
  logic              host_req, host_we, host_go;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] dm_out, host_rdata;
  logic              host_ack, host_busy;
  logic [15:0]       wr_count;

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BUS_W(BUS_W)
  ) dut (
    .clk(clk), .rst(rst), .dm_en(dm_en), .ar_in(ar_in), .bus_in(bus_in),
    .end_process(end_process), .dm_out(dm_out),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_go(host_go),
    .host_rdata(host_rdata), .host_ack(host_ack), .host_busy(host_busy),
    .wr_count(wr_count)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_RUN, M_DONE, M_ACC} mode_t;
  mode_t       m_mode = M_RUN;
  logic [11:0] m_mem [256];
  int          m_cnt = 0;
  logic [11:0] m_dm = '0, m_hr = '0;
  logic        m_ack = 1'b0;
  logic        p_we = 1'b0;
  int          p_addr = 0;
  logic [11:0] p_wd = '0;

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    if (rst) begin
      m_mode = M_RUN; m_dm = '0; m_hr = '0; m_ack = 1'b0; m_cnt = 0;
      return;
    end
    m_ack = 1'b0;
    case (m_mode)
      M_RUN: begin
        if (dm_en && int'(ar_in) < DEPTH) begin
          m_mem[ar_in[7:0]] = bus_in[11:0];
          if (m_cnt < 65535) m_cnt++;
        end
        m_dm = (int'(ar_in) < DEPTH) ? m_mem[ar_in[7:0]] : 12'h000;
        if (end_process) m_mode = M_DONE;
      end
      M_DONE: begin
        if (host_req) begin
          p_we = host_we; p_addr = int'(host_addr); p_wd = host_wdata;
          m_mode = M_ACC;
        end else if (host_go) begin
          m_cnt = 0;
          m_mode = M_RUN;
        end
      end
      M_ACC: begin
        if (p_we) begin
          if (p_addr < DEPTH) m_mem[p_addr] = p_wd;
        end else begin
          m_hr = (p_addr < DEPTH) ? m_mem[p_addr] : 12'h000;
        end
        m_ack = 1'b1;
        m_mode = M_DONE;
      end
      default: m_mode = M_RUN;
    endcase
  endtask

  task automatic chk_model();
    chk("dm_out",     32'(dm_out),     32'(m_dm));
    chk("host_rdata", 32'(host_rdata), 32'(m_hr));
    chk("host_ack",   32'(host_ack),   32'(m_ack));
    chk("host_busy",  32'(host_busy),  32'(m_mode != M_DONE));
    chk("wr_count",   32'(wr_count),   32'(m_cnt));
  endtask

  task automatic idle_inputs();
    rst = 1'b0; dm_en = 1'b0; ar_in = '0; bus_in = '0; end_process = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_go = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int rst, dm_en, ar, bus, endp, hreq, hwe, haddr, hwd, hgo;
    int e_dm, e_hr, e_ack, e_busy, e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input vec_t v);
    vecs.push_back(v);
  endtask

  initial begin
    //    rst en ar    bus      ep rq we haddr hwd    go   dm     hr     ack busy cnt
    add('{1, 0, 0,   0,       0, 0, 0, 0,   0,     0,   0,     0,     0,  1,   0});
    add('{0, 1, 5,   'h0ABC,  0, 0, 0, 0,   0,     0,   'hABC, 0,     0,  1,   1});
    add('{0, 0, 5,   0,       0, 0, 0, 0,   0,     0,   'hABC, 0,     0,  1,   1});
    add('{0, 1, 300, 'h0123,  0, 0, 0, 0,   0,     0,   0,     0,     0,  1,   1});
    add('{0, 0, 300, 0,       0, 0, 0, 0,   0,     0,   0,     0,     0,  1,   1});
    add('{0, 0, 5,   0,       0, 0, 0, 0,   0,     0,   'hABC, 0,     0,  1,   1});
    add('{0, 1, 7,   'h10055, 1, 0, 0, 0,   0,     0,   'h055, 0,     0,  0,   2});
    add('{0, 1, 5,   'h0111,  0, 1, 0, 7,   0,     0,   'h055, 0,     0,  1,   2});
    add('{0, 0, 0,   0,       0, 0, 0, 0,   0,     0,   'h055, 'h055, 1,  0,   2});
    add('{0, 0, 0,   0,       0, 0, 0, 0,   0,     0,   'h055, 'h055, 0,  0,   2});
    add('{0, 0, 0,   0,       0, 1, 1, 0,   'hFFF, 0,   'h055, 'h055, 0,  1,   2});
    add('{0, 0, 0,   0,       0, 0, 0, 0,   0,     0,   'h055, 'h055, 1,  0,   2});
    add('{0, 0, 0,   0,       0, 1, 0, 300, 0,     0,   'h055, 'h055, 0,  1,   2});
    add('{0, 0, 0,   0,       0, 0, 0, 0,   0,     0,   'h055, 0,     1,  0,   2});
    add('{0, 0, 0,   0,       0, 0, 0, 0,   0,     1,   'h055, 0,     0,  1,   0});
    add('{0, 0, 0,   0,       0, 1, 0, 5,   0,     0,   'hFFF, 0,     0,  1,   0});
    add('{0, 0, 5,   0,       0, 0, 0, 0,   0,     0,   'hABC, 0,     0,  1,   0});
    add('{0, 1, 9,   'h0222,  1, 0, 0, 0,   0,     0,   'h222, 0,     0,  0,   1});
    add('{0, 0, 0,   0,       0, 1, 1, 9,   'h777, 0,   'h222, 0,     0,  1,   1});
    add('{1, 0, 0,   0,       0, 0, 0, 0,   0,     0,   0,     0,     0,  1,   0});
    add('{0, 0, 9,   0,       0, 0, 0, 0,   0,     0,   'h222, 0,     0,  1,   0});
    add('{0, 0, 5,   0,       1, 0, 0, 0,   0,     0,   'hABC, 0,     0,  0,   0});
    add('{0, 0, 0,   0,       0, 1, 0, 9,   0,     1,   'hABC, 0,     0,  1,   0});
    add('{0, 0, 0,   0,       0, 0, 0, 0,   0,     0,   'hABC, 'h222, 1,  0,   0});
    add('{0, 0, 0,   0,       0, 0, 0, 0,   0,     1,   'hABC, 'h222, 0,  1,   0});
    add('{0, 1, 255, 'h00F0F, 0, 0, 0, 0,   0,     0,   'hF0F, 'h222, 0,  1,   1});
    add('{0, 1, 256, 'h00AAA, 0, 0, 0, 0,   0,     0,   0,     'h222, 0,  1,   1});
    add('{0, 0, 0,   0,       0, 0, 0, 0,   0,     0,   'hFFF, 'h222, 0,  1,   1});
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      model_step();
      @(posedge clk);
    end
    #1;

    // Directed table: each row is one clock, outputs checked after the edge.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst[0];           dm_en = vecs[i].dm_en[0];
      ar_in = vecs[i].ar[11:0];       bus_in = vecs[i].bus[16:0];
      end_process = vecs[i].endp[0];  host_req = vecs[i].hreq[0];
      host_we = vecs[i].hwe[0];       host_addr = vecs[i].haddr[11:0];
      host_wdata = vecs[i].hwd[11:0]; host_go = vecs[i].hgo[0];
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d dm_out", i),     32'(dm_out),     32'(vecs[i].e_dm));
      chk($sformatf("vec%0d host_rdata", i), 32'(host_rdata), 32'(vecs[i].e_hr));
      chk($sformatf("vec%0d host_ack", i),   32'(host_ack),   32'(vecs[i].e_ack));
      chk($sformatf("vec%0d host_busy", i),  32'(host_busy),  32'(vecs[i].e_busy));
      chk($sformatf("vec%0d wr_count", i),   32'(wr_count),   32'(vecs[i].e_cnt));
    end

    // Fill every word so random reads have defined contents.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      idle_inputs();
      dm_en = 1'b1; ar_in = 12'(i); bus_in = 17'($urandom);
      model_step();
      @(posedge clk);
      #1;
      chk_model();
    end

    // Randomized traffic across all states, checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 63) == 0);
      dm_en       = $urandom_range(0, 1) == 1;
      ar_in       = 12'($urandom_range(0, 319));
      bus_in      = 17'($urandom);
      end_process = ($urandom_range(0, 15) == 0);
      host_req    = ($urandom_range(0, 2) == 0);
      host_we     = $urandom_range(0, 1) == 1;
      host_addr   = 12'($urandom_range(0, 299));
      host_wdata  = 12'($urandom);
      host_go     = ($urandom_range(0, 7) == 0);
      model_step();
      @(posedge clk);
      #1;
      chk_model();
    end

    // wr_count saturation after a long run of accepted writes.
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    model_step();
    @(posedge clk);
    #1;
    chk_model();
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      idle_inputs();
      dm_en = 1'b1; ar_in = 12'($urandom_range(0, 255)); bus_in = 17'($urandom);
      model_step();
      @(posedge clk);
      #1;
      if (i == 65533) chk("wr_count_fffe", 32'(wr_count), 32'h0000_FFFE);
    end
    chk("wr_count_sat", 32'(wr_count), 32'h0000_FFFF);
    chk_model();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
